// File: rtl/sort_pkg.sv
// Shared definitions for the 4-entry sort stage and its upstream feeder:
// slot count, feeder state encoding and the pad word used to fill short batches.
package sort_pkg;

  localparam int SORT_N    = 4;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    FEED_FILL = 2'd0,
    FEED_WAIT = 2'd1,
    FEED_KICK = 2'd2
  } feed_state_t;

  // All-ones in the low `width` bits: the largest unsigned value, so pads sort last.
  function automatic logic [MAX_WIDTH-1:0] pad_word(input int width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/sort_feeder.sv
// Assembles a valid/ready word stream into padded 4-word batches, presents them
// to the sort stage and paces kicks against the sorter's busy flag.
module sort_feeder
  import sort_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [2:0]       valid_count,
  output logic             kick,
  input  logic             busy
);

  localparam logic [MAX_WIDTH-1:0] PAD_WIDE  = pad_word(WIDTH);
  localparam logic [WIDTH-1:0]     PAD       = PAD_WIDE[WIDTH-1:0];
  localparam logic [1:0]           LAST_SLOT = 2'(SORT_N - 1);

  feed_state_t                   state;
  feed_state_t                   state_next;
  logic [1:0]                    cnt;
  logic [SORT_N-1:0][WIDTH-1:0]  slot;
  logic                          accept;
  logic                          close;

  assign accept = din_valid && din_ready;
  assign close  = (cnt == LAST_SLOT) || din_last;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FEED_FILL;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      FEED_FILL: if (accept && close) state_next = FEED_WAIT;
      FEED_WAIT: if (!busy)           state_next = FEED_KICK;
      FEED_KICK: if (busy)            state_next = FEED_FILL;
      default:                        state_next = FEED_FILL;
    endcase
  end

  always_comb begin
    din_ready = (state == FEED_FILL) && !RST;
    kick      = (state == FEED_KICK);
  end

  // NOTE: only four words deep, so the slots are reset like ordinary registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot        <= '0;
      cnt         <= '0;
      valid_count <= '0;
    end else if (accept) begin
      for (int i = 0; i < SORT_N; i++) begin
        if (2'(i) == cnt)
          slot[i] <= din;
        else if (close && (2'(i) > cnt))
          slot[i] <= PAD;
      end
      if (close) begin
        valid_count <= {1'b0, cnt} + 3'd1;
        cnt         <= '0;
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  // Slots stay untouched through WAIT/KICK because no handshake happens there.
  assign out_0 = slot[0];
  assign out_1 = slot[1];
  assign out_2 = slot[2];
  assign out_3 = slot[3];

endmodule

// File: tb/tb_sort_feeder.sv
// Directed bench for sort_feeder with a minimal sorter stand-in that captures the
// slots on an idle kick and then holds busy for a fixed number of cycles.
module tb_sort_feeder;
  import sort_pkg::*;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] PAD = '1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             din_last = 1'b0;
  logic             din_ready;
  logic [WIDTH-1:0] out_0, out_1, out_2, out_3;
  logic [2:0]       valid_count;
  logic             kick;
  logic             busy;

  int checks = 0;
  int errors = 0;

  sort_feeder #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST),
    .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .valid_count(valid_count), .kick(kick), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Sorter stand-in: captures on a kick while idle, busy high for busy_len cycles from that edge.
  int busy_len = 5;
  int busy_cnt = 0;
  int kicks = 0;
  logic [WIDTH-1:0] cap [SORT_N];

  always @(posedge CLK) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (kick) begin
      cap[0]   <= out_0;
      cap[1]   <= out_1;
      cap[2]   <= out_2;
      cap[3]   <= out_3;
      busy_cnt <= busy_len;
      kicks    <= kicks + 1;
    end
  end
  assign busy = (busy_cnt != 0);

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer one word and hold it until accepted; busy_seen is busy in the accepting cycle.
  task automatic send(input logic [WIDTH-1:0] d, input logic last, output logic busy_seen);
    int   n;
    logic rdy;
    n = 0;
    din = d; din_valid = 1'b1; din_last = last;
    do begin
      rdy       = din_ready;
      busy_seen = busy;
      step();
      n++;
    end while (!rdy && n < 50);
    check_bit("accept", rdy, 1'b1);
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic wait_kick(output int cycles);
    cycles = 0;
    while (!kick && cycles < 50) begin
      step();
      cycles++;
    end
    check_bit("kick_seen", kick, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(din_ready && !busy) && n < 100) begin
      step();
      n++;
    end
    check_bit("idle_reached", din_ready && !busy, 1'b1);
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                           input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3, input logic [2:0] vc);
    check({tag, "_out0"}, out_0, e0);
    check({tag, "_out1"}, out_1, e1);
    check({tag, "_out2"}, out_2, e2);
    check({tag, "_out3"}, out_3, e3);
    check({tag, "_vc"}, 32'(valid_count), 32'(vc));
  endtask

  task automatic check_cap(input string tag, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                           input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
    check({tag, "_cap0"}, cap[0], e0);
    check({tag, "_cap1"}, cap[1], e1);
    check({tag, "_cap2"}, cap[2], e2);
    check({tag, "_cap3"}, cap[3], e3);
  endtask

  initial begin
    logic bs;
    logic bseen [4];
    int   cyc;
    int   kicks_before;

    // Reset state
    step(); step();
    check_bit("rst_din_ready", din_ready, 1'b0);
    check_bit("rst_kick", kick, 1'b0);
    check_out("rst", '0, '0, '0, '0, 3'd0);
    RST = 1'b0;
    #1;
    check_bit("post_rst_din_ready", din_ready, 1'b1);

    // Full batch 7,3,9,1 back-to-back; 4th accept at edge t
    send(32'd7, 1'b0, bs);
    send(32'd3, 1'b0, bs);
    send(32'd9, 1'b0, bs);
    send(32'd1, 1'b0, bs);
    check_out("full", 32'd7, 32'd3, 32'd9, 32'd1, 3'd4);
    check_bit("full_kick_t", kick, 1'b0);
    check_bit("full_ready_t", din_ready, 1'b0);
    step();  // t+1: kick rises
    check_bit("full_kick_t1", kick, 1'b1);
    check_bit("full_ready_t1", din_ready, 1'b0);
    step();  // t+2: sorter captured, busy rises
    check_bit("full_kick_t2", kick, 1'b1);
    check_bit("full_busy_t2", busy, 1'b1);
    check_cap("full", 32'd7, 32'd3, 32'd9, 32'd1);
    step();  // t+3: kick drops, back to FILL
    check_bit("full_kick_t3", kick, 1'b0);
    check_bit("full_ready_t3", din_ready, 1'b1);

    // Short batch 5,2 with last on 2, filled while the sorter is still busy
    send(32'd5, 1'b0, bs);
    send(32'd2, 1'b1, bs);
    check_out("short", 32'd5, 32'd2, PAD, PAD, 3'd2);
    check_bit("short_ready", din_ready, 1'b0);
    wait_kick(cyc);
    check("short_kick_delay", 32'(cyc), 32'd3);
    step();
    check_cap("short", 32'd5, 32'd2, PAD, PAD);

    // Two full batches at full rate; second fills while busy is high
    wait_idle();
    send(32'd10, 1'b0, bs);
    send(32'd20, 1'b0, bs);
    send(32'd30, 1'b0, bs);
    send(32'd40, 1'b0, bs);
    send(32'd50, 1'b0, bseen[0]);
    send(32'd60, 1'b0, bseen[1]);
    send(32'd70, 1'b0, bseen[2]);
    send(32'd80, 1'b0, bseen[3]);
    for (int i = 0; i < 4; i++) check_bit($sformatf("b2_busy_at_accept%0d", i), bseen[i], 1'b1);
    check_cap("b1_held", 32'd10, 32'd20, 32'd30, 32'd40);
    check_out("b2", 32'd50, 32'd60, 32'd70, 32'd80, 3'd4);
    check_bit("b2_kick_busy_high", kick, 1'b0);
    check_bit("b2_busy_low", busy, 1'b0);
    step();  // first edge sampling busy=0 raises the second kick
    check_bit("b2_kick_first_idle", kick, 1'b1);
    step();
    check_cap("b2", 32'd50, 32'd60, 32'd70, 32'd80);

    // Gaps with din_last asserted while din_valid is low
    wait_idle();
    din_last = 1'b1;
    step();
    check_bit("gap_no_close0", din_ready, 1'b1);
    send(32'd11, 1'b0, bs);
    din_last = 1'b1;
    step();
    send(32'd12, 1'b0, bs);
    din_last = 1'b1;
    step(); step();
    check_bit("gap_no_close1", din_ready, 1'b1);
    send(32'd13, 1'b1, bs);
    check_out("gap", 32'd11, 32'd12, 32'd13, PAD, 3'd3);
    wait_kick(cyc);
    step();
    check_cap("gap", 32'd11, 32'd12, 32'd13, PAD);

    // Reset in FILL with cnt=2
    wait_idle();
    send(32'd21, 1'b0, bs);
    send(32'd22, 1'b0, bs);
    #2 RST = 1'b1;
    #1;
    check_bit("rfill_ready", din_ready, 1'b0);
    check_bit("rfill_kick", kick, 1'b0);
    check_out("rfill", '0, '0, '0, '0, 3'd0);
    #2 RST = 1'b0;
    step();
    send(32'd31, 1'b0, bs);
    send(32'd32, 1'b1, bs);
    check_out("rfill_next", 32'd31, 32'd32, PAD, PAD, 3'd2);
    wait_kick(cyc);
    step();
    check_cap("rfill_next", 32'd31, 32'd32, PAD, PAD);

    // Reset during KICK
    wait_idle();
    send(32'd41, 1'b1, bs);
    wait_kick(cyc);
    kicks_before = kicks;
    #2 RST = 1'b1;
    #1;
    check_bit("rkick_kick", kick, 1'b0);
    check_out("rkick", '0, '0, '0, '0, 3'd0);
    #3 RST = 1'b0;
    step();
    check("rkick_no_capture", 32'(kicks), 32'(kicks_before));

    // Single-word batch of value 0
    send(32'd0, 1'b1, bs);
    check_out("single", 32'd0, PAD, PAD, PAD, 3'd1);
    wait_kick(cyc);
    step();
    check_cap("single", 32'd0, PAD, PAD, PAD);
    check("single_kick_count", 32'(kicks), 32'(kicks_before + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
